// File: rtl/mat_stream_loader.sv
// mat_stream_loader
//   Turns the host load stream into SRAM writes for the weight memory and the
//   first-layer feature buffer. A command selects either a weight layer range
//   or a feature load; payload beats of LANES x DW bits are then counted and
//   written one cycle after acceptance with registered address and data.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_valid / cmd_ready      command handshake (ready only in IDLE)
//   cmd_mode                   0 = weight load, 1 = feature load
//   cmd_layer_base/_cnt        weight layer range (weight mode only)
//   in_valid / in_ready        payload beat handshake
//   in_payload                 lane k = bits [k*DW +: DW]
//   w_we/w_addr/w_wdata        weight memory write port
//   f_we/f_addr/f_wdata        feature memory write port
//   done                       one-cycle pulse when a load completes
//   err                        sticky command error, cleared by next command
//   beat_cnt                   beats accepted in current/most recent load
module mat_stream_loader #(
  parameter int DW      = 16,
  parameter int LANES   = 2,
  parameter int LAYER_N = 8,
  parameter int MAT_R   = 16,
  parameter int MAT_C   = 16,
  parameter int W_AW    = $clog2(LAYER_N*MAT_R*MAT_C/LANES),
  parameter int F_AW    = $clog2(MAT_R*MAT_C/LANES)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_mode,
  input  logic [$clog2(LAYER_N)-1:0]  cmd_layer_base,
  input  logic [$clog2(LAYER_N):0]    cmd_layer_cnt,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DW*LANES-1:0]         in_payload,
  output logic                        w_we,
  output logic [W_AW-1:0]             w_addr,
  output logic [DW*LANES-1:0]         w_wdata,
  output logic                        f_we,
  output logic [F_AW-1:0]             f_addr,
  output logic [DW*LANES-1:0]         f_wdata,
  output logic                        done,
  output logic                        err,
  output logic [15:0]                 beat_cnt
);

  localparam int BUS_W       = DW*LANES;
  // Beats per weight layer; also the beat count of one feature load since
  // (MAT_R/LANES)*MAT_C == MAT_R*(MAT_C/LANES).
  localparam int LAYER_WORDS = MAT_R*MAT_C/LANES;
  localparam int CNT_W       = W_AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD_W = 2'd1,
    ST_LOAD_F = 2'd2,
    ST_FLUSH  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   total_q, total_d;
  logic [W_AW-1:0]    w_base_q, w_base_d;
  logic [15:0]        beat_cnt_q, beat_cnt_d;
  logic               err_q, err_d;
  logic               done_q, done_d;
  logic               rdy_q;
  logic               w_we_q, w_we_d;
  logic [W_AW-1:0]    w_addr_q, w_addr_d;
  logic [BUS_W-1:0]   w_wdata_q, w_wdata_d;
  logic               f_we_q, f_we_d;
  logic [F_AW-1:0]    f_addr_q, f_addr_d;
  logic [BUS_W-1:0]   f_wdata_q, f_wdata_d;

  logic               cmd_fire;
  logic               beat_fire;
  logic               cmd_bad;
  logic [31:0]        layer_end;
  logic               loading;

  assign loading = (state_q == ST_LOAD_W) || (state_q == ST_LOAD_F);

  // rdy_q keeps cmd_ready low while reset is held and until the first edge
  // after release. done_q masks the done cycle so a new command can only be
  // taken the cycle after the done pulse.
  assign cmd_ready = rdy_q && (state_q == ST_IDLE) && !done_q;
  assign in_ready  = loading && (idx_q < total_q);

  assign cmd_fire  = cmd_valid && cmd_ready;
  assign beat_fire = in_valid && in_ready;

  assign layer_end = 32'(cmd_layer_base) + 32'(cmd_layer_cnt);
  assign cmd_bad   = (cmd_layer_cnt == '0) || (layer_end > 32'(LAYER_N));

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    total_d    = total_q;
    w_base_d   = w_base_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q;
    done_d     = 1'b0;
    w_we_d     = 1'b0;
    w_addr_d   = w_addr_q;
    w_wdata_d  = w_wdata_q;
    f_we_d     = 1'b0;
    f_addr_d   = f_addr_q;
    f_wdata_d  = f_wdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          err_d      = 1'b0;
          beat_cnt_d = '0;
          idx_d      = '0;
          if (!cmd_mode) begin
            if (cmd_bad) begin
              err_d = 1'b1;
            end else begin
              state_d  = ST_LOAD_W;
              total_d  = CNT_W'(cmd_layer_cnt) * CNT_W'(LAYER_WORDS);
              w_base_d = W_AW'(cmd_layer_base) * W_AW'(LAYER_WORDS);
            end
          end else begin
            state_d = ST_LOAD_F;
            total_d = CNT_W'(LAYER_WORDS);
          end
        end
      end

      ST_LOAD_W, ST_LOAD_F: begin
        if (beat_fire) begin
          idx_d = idx_q + CNT_W'(1);
          if (beat_cnt_q != '1) begin
            beat_cnt_d = beat_cnt_q + 16'd1;
          end
          if (state_q == ST_LOAD_W) begin
            w_we_d    = 1'b1;
            w_addr_d  = w_base_q + W_AW'(idx_q);
            w_wdata_d = in_payload;
          end else begin
            f_we_d    = 1'b1;
            f_addr_d  = F_AW'(idx_q);
            f_wdata_d = in_payload;
          end
          if (idx_d == total_q) begin
            state_d = ST_FLUSH;
          end
        end
      end

      ST_FLUSH: begin
        // The final write is on the bus this cycle; done follows it.
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      total_q    <= '0;
      w_base_q   <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      rdy_q      <= 1'b0;
      w_we_q     <= 1'b0;
      w_addr_q   <= '0;
      w_wdata_q  <= '0;
      f_we_q     <= 1'b0;
      f_addr_q   <= '0;
      f_wdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      total_q    <= total_d;
      w_base_q   <= w_base_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
      done_q     <= done_d;
      rdy_q      <= 1'b1;
      w_we_q     <= w_we_d;
      w_addr_q   <= w_addr_d;
      w_wdata_q  <= w_wdata_d;
      f_we_q     <= f_we_d;
      f_addr_q   <= f_addr_d;
      f_wdata_q  <= f_wdata_d;
    end
  end

  assign w_we     = w_we_q;
  assign w_addr   = w_addr_q;
  assign w_wdata  = w_wdata_q;
  assign f_we     = f_we_q;
  assign f_addr   = f_addr_q;
  assign f_wdata  = f_wdata_q;
  assign done     = done_q;
  assign err      = err_q;
  assign beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_mat_stream_loader.sv
module tb_mat_stream_loader;

  localparam int DW      = 16;
  localparam int LANES   = 2;
  localparam int LAYER_N = 8;
  localparam int MAT_R   = 16;
  localparam int MAT_C   = 16;
  localparam int W_AW    = 10;
  localparam int F_AW    = 7;
  localparam int BUS_W   = DW*LANES;
  localparam int W_WORDS = LAYER_N*MAT_R*MAT_C/LANES;
  localparam int LIMIT   = 5000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_mode = 1'b0;
  logic [2:0]        cmd_layer_base = '0;
  logic [3:0]        cmd_layer_cnt = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [BUS_W-1:0]  in_payload = '0;
  logic              w_we;
  logic [W_AW-1:0]   w_addr;
  logic [BUS_W-1:0]  w_wdata;
  logic              f_we;
  logic [F_AW-1:0]   f_addr;
  logic [BUS_W-1:0]  f_wdata;
  logic              done;
  logic              err;
  logic [15:0]       beat_cnt;

  mat_stream_loader #(
    .DW(DW), .LANES(LANES), .LAYER_N(LAYER_N), .MAT_R(MAT_R), .MAT_C(MAT_C),
    .W_AW(W_AW), .F_AW(F_AW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_layer_base(cmd_layer_base), .cmd_layer_cnt(cmd_layer_cnt),
    .in_valid(in_valid), .in_ready(in_ready), .in_payload(in_payload),
    .w_we(w_we), .w_addr(w_addr), .w_wdata(w_wdata),
    .f_we(f_we), .f_addr(f_addr), .f_wdata(f_wdata),
    .done(done), .err(err), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       mode;
    int         base;
    int         cnt;
    bit         gap;
    bit         extra;
    bit         exp_err;
    int         total;
    int         addr0;
    int         seed;
  } vec_t;

  typedef struct {
    logic              is_w;
    logic [W_AW-1:0]   addr;
    logic [BUS_W-1:0]  data;
  } wr_t;

  wr_t  sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc_cnt = 0;
  int   n_w, n_f, n_done, first_addr, last_addr, last_we_cyc;
  bit   have_first;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc_cnt++;

  // Write monitor / scoreboard consumer
  always @(negedge clk) begin
    wr_t e;
    if (w_we) begin
      assert (int'(w_addr) < W_WORDS) else $error("w_addr out of range %0d", w_addr);
    end
    if (w_we || f_we) begin
      chk("we_exclusive", {63'd0, w_we && f_we}, 64'd0);
      if (sb.size() == 0) begin
        chk("unexpected_write", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("wr_kind", {63'd0, w_we}, {63'd0, e.is_w});
        chk("wr_addr", w_we ? 64'(w_addr) : 64'(f_addr), 64'(e.addr));
        chk("wr_data", w_we ? 64'(w_wdata) : 64'(f_wdata), 64'(e.data));
      end
      if (w_we) n_w++;
      if (f_we) n_f++;
      if (!have_first) begin
        first_addr = w_we ? int'(w_addr) : int'(f_addr);
        have_first = 1'b1;
      end
      last_addr   = w_we ? int'(w_addr) : int'(f_addr);
      last_we_cyc = cyc_cnt;
    end
    if (done) n_done++;
  end

  task automatic clr();
    n_w = 0; n_f = 0; n_done = 0; have_first = 1'b0;
    first_addr = -1; last_addr = -1; last_we_cyc = -100;
  endtask

  task automatic issue_cmd(input vec_t v, input bit hold);
    int t;
    clr();
    @(negedge clk);
    cmd_valid      = 1'b1;
    cmd_mode       = v.mode;
    cmd_layer_base = 3'(v.base);
    cmd_layer_cnt  = 4'(v.cnt);
    t = 0;
    while (!cmd_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("cmd_accept_ready", {63'd0, cmd_ready}, 64'd1);
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic send_beats(input vec_t v, input int n, output int acc);
    int cyc;
    acc = 0;
    cyc = 0;
    while (acc < n && cyc < LIMIT) begin
      in_valid   = !(v.gap && (cyc % 3 == 2));
      in_payload = BUS_W'((v.seed << 16) | acc);
      if (in_valid && in_ready) begin
        wr_t e;
        e.is_w = !v.mode;
        e.addr = W_AW'(v.addr0 + acc);
        e.data = in_payload;
        sb.push_back(e);
        acc++;
      end
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic do_beats(input vec_t v);
    int acc;
    int t;
    chk("err_clear_on_cmd", {63'd0, err}, 64'd0);
    send_beats(v, v.total, acc);
    chk("beats_accepted", 64'(acc), 64'(v.total));
    if (v.extra) begin
      chk("in_ready_low_after_total", {63'd0, in_ready}, 64'd0);
      in_valid   = 1'b1;
      in_payload = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("in_ready_low_extra", {63'd0, in_ready}, 64'd0);
      in_valid = 1'b0;
    end
    t = 0;
    while (!done && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", {63'd0, done}, 64'd1);
    chk("cmd_ready_low_in_done", {63'd0, cmd_ready}, 64'd0);
    chk("done_after_last_write", 64'(cyc_cnt - last_we_cyc), 64'd1);
    @(negedge clk);
    chk("done_one_cycle", {63'd0, done}, 64'd0);
    chk("cmd_ready_after_done", {63'd0, cmd_ready}, 64'd1);
    chk("done_count", 64'(n_done), 64'd1);
    chk("beat_cnt", 64'(beat_cnt), 64'(v.total));
    chk("n_w", 64'(n_w), v.mode ? 64'd0 : 64'(v.total));
    chk("n_f", 64'(n_f), v.mode ? 64'(v.total) : 64'd0);
    chk("first_addr", 64'(first_addr), 64'(v.addr0));
    chk("last_addr", 64'(last_addr), 64'(v.addr0 + v.total - 1));
    chk("sb_empty", 64'(sb.size()), 64'd0);
    chk("err_low", {63'd0, err}, 64'd0);
  endtask

  task automatic do_err_case(input vec_t v);
    issue_cmd(v, 1'b0);
    chk("err_set", {63'd0, err}, 64'd1);
    chk("err_ready_stays", {63'd0, cmd_ready}, 64'd1);
    repeat (4) @(negedge clk);
    chk("err_no_writes", 64'(n_w + n_f), 64'd0);
    chk("err_no_done", 64'(n_done), 64'd0);
    chk("err_beat_cnt", 64'(beat_cnt), 64'd0);
    chk("err_sticky", {63'd0, err}, 64'd1);
    chk("err_ready_idle", {63'd0, cmd_ready}, 64'd1);
  endtask

  vec_t vecs[7];
  vec_t vh;
  int   acc;

  initial begin
    //         mode base cnt gap extra err total addr0 seed
    vecs[0] = '{mode:1'b0, base:0, cnt:8, gap:1'b0, extra:1'b0, exp_err:1'b0, total:1024, addr0:0,   seed:0};
    vecs[1] = '{mode:1'b1, base:0, cnt:0, gap:1'b1, extra:1'b0, exp_err:1'b0, total:128,  addr0:0,   seed:1};
    vecs[2] = '{mode:1'b0, base:5, cnt:2, gap:1'b0, extra:1'b1, exp_err:1'b0, total:256,  addr0:640, seed:2};
    vecs[3] = '{mode:1'b0, base:6, cnt:3, gap:1'b0, extra:1'b0, exp_err:1'b1, total:0,    addr0:0,   seed:0};
    vecs[4] = '{mode:1'b1, base:0, cnt:0, gap:1'b0, extra:1'b1, exp_err:1'b0, total:128,  addr0:0,   seed:3};
    vecs[5] = '{mode:1'b0, base:0, cnt:0, gap:1'b0, extra:1'b0, exp_err:1'b1, total:0,    addr0:0,   seed:0};
    vecs[6] = '{mode:1'b0, base:7, cnt:1, gap:1'b1, extra:1'b1, exp_err:1'b0, total:128,  addr0:896, seed:4};

    clr();
    #1;
    chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    chk("rst_flags", {58'd0, w_we, f_we, done, err, in_ready, cmd_ready}, 64'd0);
    chk("rst_beat_cnt", 64'(beat_cnt), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {63'd0, cmd_ready}, 64'd1);

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].exp_err) begin
        do_err_case(vecs[i]);
      end else begin
        issue_cmd(vecs[i], 1'b0);
        do_beats(vecs[i]);
      end
    end

    // Reset in the middle of a weight load
    vh = '{mode:1'b0, base:2, cnt:1, gap:1'b0, extra:1'b0, exp_err:1'b0, total:128, addr0:256, seed:5};
    issue_cmd(vh, 1'b0);
    send_beats(vh, 50, acc);
    chk("pre_reset_beats", 64'(acc), 64'd50);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_flags", {58'd0, w_we, f_we, done, err, in_ready, cmd_ready}, 64'd0);
    chk("abort_beat_cnt", 64'(beat_cnt), 64'd0);
    chk("abort_w_addr", 64'(w_addr), 64'd0);
    chk("abort_w_wdata", 64'(w_wdata), 64'd0);
    chk("abort_sb_empty", 64'(sb.size()), 64'd0);
    @(negedge clk);
    chk("ready_in_reset", {63'd0, cmd_ready}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_abort", {63'd0, cmd_ready}, 64'd1);
    chk("abort_no_done", 64'(n_done), 64'd0);
    chk("abort_no_writes", 64'(n_w), 64'd50);
    issue_cmd(vh, 1'b0);
    chk("restart_beat_cnt", 64'(beat_cnt), 64'd0);
    do_beats(vh);

    // cmd_valid held through a feature load
    vh = '{mode:1'b1, base:0, cnt:0, gap:1'b0, extra:1'b0, exp_err:1'b0, total:128, addr0:0, seed:6};
    issue_cmd(vh, 1'b1);
    cmd_mode       = 1'b0;
    cmd_layer_base = 3'd0;
    cmd_layer_cnt  = 4'd1;
    do_beats(vh);
    @(negedge clk);
    chk("held_cmd_accepted", {62'd0, cmd_ready, in_ready}, 64'd1);
    chk("held_cmd_beat_cnt", 64'(beat_cnt), 64'd0);
    cmd_valid = 1'b0;
    clr();
    vh = '{mode:1'b0, base:0, cnt:1, gap:1'b0, extra:1'b0, exp_err:1'b0, total:128, addr0:0, seed:7};
    do_beats(vh);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mat_stream_loader.md
Name: mat_stream_loader

Overview:
Parametrised front-end loader that turns the 32-bit host load stream into SRAM writes for the weight memory and the first-layer feature buffer. It generalises the fixed 2×16-bit packing to LANES×DW beats, with configurable layer count and matrix size. It adds a command handshake that selects a weight layer range or a feature load, plus beat counting, done pulses and protocol-error detection. It sits between the top-level load interface and the weight/feature memories, ahead of the MAC array.

Parameters:
DW, 16, element width in bits.
LANES, 2, elements per payload beat; BUS_W = DW*LANES.
LAYER_N, 8, number of weight layers.
MAT_R, 16, matrix rows; must be a multiple of LANES.
MAT_C, 16, matrix columns; must be a multiple of LANES.
W_AW, $clog2(LAYER_N*MAT_R*MAT_C/LANES), weight memory address width; 10 at defaults.
F_AW, $clog2(MAT_R*MAT_C/LANES), feature memory address width; 7 at defaults.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accept; high only in IDLE
cmd_mode  in  1  0 = weight load, 1 = feature load
cmd_layer_base  in  $clog2(LAYER_N)  first layer to load (weight mode only)
cmd_layer_cnt  in  $clog2(LAYER_N)+1  number of layers to load (weight mode only)
in_valid  in  1  payload beat valid
in_ready  out  1  payload beat accept
in_payload  in  BUS_W  lane k = bits [k*DW +: DW]
w_we  out  1  weight memory write enable
w_addr  out  W_AW  weight memory address
w_wdata  out  BUS_W  weight memory write data
f_we  out  1  feature memory write enable
f_addr  out  F_AW  feature memory address
f_wdata  out  BUS_W  feature memory write data
done  out  1  one-cycle pulse when a load completes
err  out  1  sticky command error; cleared by the next accepted command
beat_cnt  out  16  beats accepted in the current or most recent load

Behaviour:
- Reset: all outputs 0 (cmd_ready reads 0 during reset and goes to 1 on the first clk edge after release, i.e. entry to IDLE); state = IDLE; all counters 0. Reset asserted mid-load aborts the load immediately; no further writes are issued.
- States: IDLE, LOAD_W, LOAD_F, FLUSH.
- IDLE: cmd_ready = 1. On cmd_valid & cmd_ready:
  - Clear err and beat_cnt.
  - Weight mode with cmd_layer_cnt = 0 or cmd_layer_base + cmd_layer_cnt > LAYER_N: set err, stay in IDLE, no done.
  - Otherwise go to LOAD_W, or to LOAD_F for feature mode.
- Beat totals:
  - LOAD_W: total = cmd_layer_cnt*MAT_R*(MAT_C/LANES). Beat order is layer, then row, then column group; lane k holds column grp*LANES+k.
  - LOAD_F: total = (MAT_R/LANES)*MAT_C. Beat order is row group, then column; lane k holds row rg*LANES+k.
- in_ready = 1 in LOAD_W/LOAD_F while accepted beats < total, else 0. A beat is accepted on in_valid & in_ready. in_valid gaps are legal and stall the counters.
- Write pipeline: each accepted beat produces exactly one write on the next cycle (latency 1), with registered data.
  - Weight address: w_addr = cmd_layer_base*MAT_R*MAT_C/LANES + beat index.
  - Feature address: f_addr = beat index.
  - w_we and f_we are never high together. Neither is high outside the cycle after an accepted beat.
- beat_cnt increments per accepted beat and saturates at 16'hFFFF. Its value holds after done until the next accepted command.
- On the last beat accepted, go to FLUSH. In FLUSH the final write is issued, done pulses for 1 cycle, and the FSM returns to IDLE. cmd_ready is high again the cycle after done.
- cmd_valid while not in IDLE is ignored (cmd_ready = 0) and is not an error.
- Address wrap cannot occur for legal commands. The bench checks this with an assertion that w_addr < LAYER_N*MAT_R*MAT_C/LANES.

Test Plan:
- Reset, then weight cmd base=0 cnt=8, 1024 back-to-back beats with payload = beat index -> w_we high 1024 cycles; w_addr 0..1023 in order; w_wdata[31:0] = addr; single done 1 cycle after last w_we; beat_cnt = 1024.
- Feature cmd, 128 beats with in_valid low every 3rd cycle -> f_addr 0..127 contiguous, no w_we, f_we only the cycle after each accepted beat; done once; beat_cnt = 128.
- Weight cmd base=5 cnt=2 -> 256 writes at w_addr 640..895; in_ready drops after beat 256 and an extra in_valid beat is not accepted.
- Weight cmd base=6 cnt=3 -> err = 1, cmd_ready stays 1, no writes, no done; a following legal feature cmd clears err.
- rst_n low at beat 50 of a weight load -> all outputs 0 asynchronously, no done; the next command after release starts with beat_cnt = 0 and w_addr from base.
- cmd_valid held high during LOAD_F -> ignored; exactly one done, then the held command is accepted in IDLE the cycle after done.
